lfsr_scramble_sync_ctrl: RTL and testbench

Stream controller that sequences an internal `lfsr_scramble` instance for framed serial links. It accepts data words over a valid/ready stream and passes them through the scrambler. Every `SYNC_PERIOD` data words, or on request, it inserts one unscrambled sync word and reseeds the scrambler to `LFSR_INIT`, so a receiver can realign its descrambler. It sits between the link framer and the serializer.

---
 rtl/lfsr_scramble_sync_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lfsr_scramble_sync_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_scramble_sync_ctrl.sv
//------------------------------------------------------------------------------
// lfsr_scramble_sync_ctrl : valid/ready scrambling stage with periodic sync-word
//                           insertion and scrambler reseed for receiver realign
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_scramble #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    LFSR_WIDTH  = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 58'h8000000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
    parameter string                 LFSR_CONFIG = "FIBONACCI",
    parameter bit                    REVERSE     = 1'b1,
    parameter string                 STYLE       = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int BW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

    logic [LFSR_WIDTH-1:0] state_reg;
    logic [DATA_WIDTH-1:0] out_reg;

    // Self-synchronising scrambler: the LFSR is fed with its own output bits.
    function automatic logic [LFSR_WIDTH+DATA_WIDTH-1:0] scramble_word(
        input logic [LFSR_WIDTH-1:0] s_in,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [LFSR_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] o;
        logic [BW-1:0]         b;
        logic                  fb;
        s  = s_in;
        o  = '0;
        fb = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b = BW'((REVERSE != 1'b0) ? i : DATA_WIDTH - 1 - i);
            if (GALOIS) begin
                o[b] = d[b] ^ s[LFSR_WIDTH-1];
                s    = {s[LFSR_WIDTH-2:0], 1'b0} ^ (o[b] ? LFSR_POLY : '0);
            end else begin
                fb   = s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
                o[b] = d[b] ^ fb;
                s    = {s[LFSR_WIDTH-2:0], o[b]};
            end
        end
        return {s, o};
    endfunction

    // Every implementation style resolves to the same unrolled loop.
    generate
        if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_style_other
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LFSR_INIT;
            out_reg   <= '0;
        end else if (data_in_valid) begin
            {state_reg, out_reg} <= scramble_word(state_reg, data_in);
        end
    end

    assign data_out = out_reg;

endmodule

module lfsr_scramble_sync_ctrl #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    LFSR_WIDTH  = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 58'h8000000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
    parameter string                 LFSR_CONFIG = "FIBONACCI",
    parameter bit                    REVERSE     = 1'b1,
    parameter string                 STYLE       = "AUTO",
    parameter int                    SYNC_PERIOD = 1024,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 64'h78F0_78F0_78F0_78F0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tsync,
    input  logic                  force_sync,
    output logic [15:0]           sync_count
);

    localparam int              CW     = $clog2(SYNC_PERIOD + 1);
    localparam logic [CW-1:0]   LAST   = CW'(SYNC_PERIOD - 1);
    localparam logic [0:0]      S_SYNC = 1'b0;
    localparam logic [0:0]      S_RUN  = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [CW-1:0]         word_cnt;
    logic                  force_pend;
    logic                  inflight;
    logic                  accept;
    logic                  pop;
    logic                  sync_write;
    logic                  fifo_wr;
    logic [DATA_WIDTH:0]   fifo_wdata;
    logic [DATA_WIDTH:0]   fifo_mem [4];
    logic [DATA_WIDTH:0]   fifo_head;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_count;
    logic [DATA_WIDTH-1:0] scr_out;

    assign accept = s_axis_tvalid & s_axis_tready;
    assign pop    = m_axis_tvalid & m_axis_tready;

    lfsr_scramble #(
        .DATA_WIDTH  (DATA_WIDTH),
        .LFSR_WIDTH  (LFSR_WIDTH),
        .LFSR_POLY   (LFSR_POLY),
        .LFSR_INIT   (LFSR_INIT),
        .LFSR_CONFIG (LFSR_CONFIG),
        .REVERSE     (REVERSE),
        .STYLE       (STYLE)
    ) u_scramble (
        .clk           (clk),
        .rst           (rst | sync_write),
        .data_in       (s_axis_tdata),
        .data_in_valid (accept),
        .data_out      (scr_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // A force request is honoured only after the word accepted alongside it.
    always_comb begin
        state_next = state;
        case (state)
            S_SYNC: if (sync_write) state_next = S_RUN;
            S_RUN:  if (force_pend || (accept && (word_cnt == LAST || force_sync)))
                        state_next = S_SYNC;
            default: state_next = S_SYNC;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        sync_write    = 1'b0;
        case (state)
            S_SYNC: sync_write    = !inflight && (fifo_count < 3'd4);
            S_RUN:  s_axis_tready = ({1'b0, fifo_count} + {3'b000, inflight}) <= 4'd2;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            force_pend <= 1'b0;
            inflight   <= 1'b0;
            sync_count <= '0;
        end else begin
            inflight <= accept;
            if (sync_write) begin
                word_cnt   <= '0;
                force_pend <= 1'b0;
                sync_count <= sync_count + 16'd1;
            end else begin
                if (force_sync) force_pend <= 1'b1;
                if (accept) word_cnt <= (state_next == S_SYNC) ? '0 : word_cnt + 1'b1;
            end
        end
    end

    // A sync is only written with nothing in flight, so the two sources never collide.
    assign fifo_wr    = inflight | sync_write;
    assign fifo_wdata = sync_write ? {1'b1, SYNC_WORD} : {1'b0, scr_out};

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= fifo_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + {2'b00, fifo_wr} - {2'b00, pop};
        end
    end

    assign fifo_head     = fifo_mem[rd_ptr];
    assign m_axis_tvalid = (fifo_count != 3'd0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tsync  = m_axis_tvalid & fifo_head[DATA_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_lfsr_scramble_sync_ctrl.sv
//------------------------------------------------------------------------------
// tb_lfsr_scramble_sync_ctrl : scoreboard bench, SYNC_PERIOD 4 and 1024 instances
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lfsr_scramble_sync_ctrl;

    localparam logic [63:0] SYNC = 64'h78F0_78F0_78F0_78F0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] sd0, sd1;
    logic        sv0, sv1, fs0, fs1, mr0, mr1;
    logic        rdy0, rdy1, mv0, mv1, ms0, ms1;
    logic [63:0] md0, md1;
    logic [15:0] sc0, sc1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          first_acc  = -1;
    int          first_dpop = -1;

    int          acc_cnt [2];
    int          pop_cnt [2];
    int          mcnt    [2];
    int          msyncs  [2];
    logic [57:0] mst     [2];
    logic [64:0] q0 [$];
    logic [64:0] q1 [$];

    always #5 clk = ~clk;

    lfsr_scramble_sync_ctrl #(.SYNC_PERIOD(4)) dut_p4 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(sd0), .s_axis_tvalid(sv0), .s_axis_tready(rdy0),
        .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(mr0),
        .m_axis_tsync(ms0), .force_sync(fs0), .sync_count(sc0)
    );

    lfsr_scramble_sync_ctrl #(.SYNC_PERIOD(1024)) dut_p1k (
        .clk(clk), .rst(rst),
        .s_axis_tdata(sd1), .s_axis_tvalid(sv1), .s_axis_tready(rdy1),
        .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(mr1),
        .m_axis_tsync(ms1), .force_sync(fs1), .sync_count(sc1)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // x^58 + x^39 + 1, LSB first, fed back with the scrambled bit.
    task automatic ref_scramble(inout logic [57:0] st, input logic [63:0] d, output logic [63:0] o);
        logic fb;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            fb   = st[57] ^ st[38];
            o[i] = d[i] ^ fb;
            st   = {st[56:0], o[i]};
        end
    endtask

    task automatic qpush(input int k, input logic [64:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_accept(input int k, input logic [63:0] d, input logic f);
        logic [57:0] st;
        logic [63:0] o;
        st = mst[k];
        ref_scramble(st, d, o);
        mst[k] = st;
        qpush(k, {1'b0, o});
        mcnt[k]++;
        if (mcnt[k] == ((k == 0) ? 4 : 1024) || f) begin
            qpush(k, {1'b1, SYNC});
            mcnt[k]   = 0;
            msyncs[k]++;
            mst[k]    = '1;
        end
    endtask

    task automatic proc_inst(input int k, input logic rdy, input logic sv, input logic [63:0] sd,
                             input logic fs, input logic mv, input logic mr, input logic ms,
                             input logic [63:0] md, input logic [15:0] sc);
        int          occ;
        logic [64:0] exp;
        string       tag;
        if (rst) return;
        occ = acc_cnt[k] + int'(sc) - pop_cnt[k];
        if (rdy) check_val((k == 0) ? "p4_ready_occ" : "p1k_ready_occ", 128'(occ <= 2), 128'(1));
        if (mv)  check_val((k == 0) ? "p4_fifo_bound" : "p1k_fifo_bound", 128'(occ <= 4), 128'(1));
        if (mv && mr) begin
            tag = (k == 0) ? "p4_word" : "p1k_word";
            if (qsize(k) == 0) begin
                check_val({tag, "_unexpected"}, 128'(qsize(k)), 128'(1));
            end else begin
                exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                check_val(tag, 128'({ms, md}), 128'(exp));
            end
            pop_cnt[k]++;
            if (k == 0 && !ms && first_dpop < 0) first_dpop = cyc;
        end
        if (sv && rdy) begin
            acc_cnt[k]++;
            if (k == 0 && first_acc < 0) first_acc = cyc;
            model_accept(k, sd, fs);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        proc_inst(0, rdy0, sv0, sd0, fs0, mv0, mr0, ms0, md0, sc0);
        proc_inst(1, rdy1, sv1, sd1, fs1, mv1, mr1, ms1, md1, sc1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sv0 = 1'b0; sv1 = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
        cycle();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            acc_cnt[k] = 0; pop_cnt[k] = 0; mcnt[k] = 0; msyncs[k] = 1; mst[k] = '1;
            qpush(k, {1'b1, SYNC});
        end
        check_val("rst_tvalid",  128'(mv0),  128'(0));
        check_val("rst_tready",  128'(rdy0), 128'(0));
        check_val("rst_tsync",   128'(ms0),  128'(0));
        check_val("rst_tdata",   128'(md0),  128'(0));
        check_val("rst_synccnt", 128'(sc0),  128'(0));
        check_val("rst_tvalid_p1k", 128'(mv1), 128'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        sv0 = 1'b0; sv1 = 1'b0; mr0 = 1'b1; mr1 = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            cycle();
            n++;
        end
        check_val("drain_p4",  128'(q0.size()), 128'(0));
        check_val("drain_p1k", 128'(q1.size()), 128'(0));
        check_val("synccnt_p4",  128'(sc0), 128'(msyncs[0]));
        check_val("synccnt_p1k", 128'(sc1), 128'(msyncs[1]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   guard;
        logic done;
        sd0 = '0; sd1 = '0; sv0 = 1'b0; sv1 = 1'b0;
        fs0 = 1'b0; fs1 = 1'b0; mr0 = 1'b1; mr1 = 1'b1;

        // Continuous zero words: sync every 4 words, identical data blocks.
        do_reset();
        sv0 = 1'b1; sd0 = '0;
        repeat (40) cycle();
        drain();
        check_val("latency_first_word", 128'(first_dpop - first_acc), 128'(2));

        // Random input valid and output ready.
        for (int i = 0; i < 400; i++) begin
            sv0 = 1'($urandom_range(0, 1));
            mr0 = 1'($urandom_range(0, 1));
            sd0 = {$urandom, $urandom};
            cycle();
        end
        drain();

        // Output stalled from reset: sync plus two words held.
        do_reset();
        sv0 = 1'b1; mr0 = 1'b0;
        repeat (10) begin
            sd0 = {$urandom, $urandom};
            cycle();
        end
        check_val("stall_tready",   128'(rdy0),       128'(0));
        check_val("stall_accepted", 128'(acc_cnt[0]), 128'(2));
        check_val("stall_head_sync", 128'(ms0),       128'(1));
        drain();

        // force_sync together with the accept of the last word of a period.
        sv0 = 1'b1; mr0 = 1'b1; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sd0 = {$urandom, $urandom};
            fs0 = (!done && i > 10 && mcnt[0] == 3 && rdy0);
            if (fs0) done = 1'b1;
            cycle();
            fs0 = 1'b0;
        end
        check_val("force_last_hit", 128'(done), 128'(1));
        drain();

        // Reset with words buffered, then restart from a fresh seed.
        sv0 = 1'b1; mr0 = 1'b1;
        repeat (6) begin sd0 = {$urandom, $urandom}; cycle(); end
        mr0 = 1'b0;
        repeat (5) begin sd0 = {$urandom, $urandom}; cycle(); end
        check_val("pre_rst_buffered", 128'((acc_cnt[0] + int'(sc0) - pop_cnt[0]) >= 3), 128'(1));
        do_reset();
        sv0 = 1'b1; mr0 = 1'b1;
        repeat (20) begin sd0 = {$urandom, $urandom}; cycle(); end
        drain();

        // Forced sync after word 2 with period 1024, then the next periodic sync.
        sv1 = 1'b1; mr1 = 1'b1; done = 1'b0; guard = 0;
        while (acc_cnt[1] < 2 + 1024 + 3 && guard < 1300) begin
            sd1 = {$urandom, $urandom};
            fs1 = (!done && acc_cnt[1] == 1 && rdy1);
            if (fs1) done = 1'b1;
            cycle();
            fs1 = 1'b0;
            guard++;
        end
        check_val("p1k_force_hit", 128'(done), 128'(1));
        check_val("p1k_words_accepted", 128'(acc_cnt[1]), 128'(2 + 1024 + 3));
        drain();
        check_val("p1k_sync_total", 128'(sc1), 128'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
